// File: rtl/ama_riscv_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : ama_riscv_uart_tx_if
// Description : MMIO write handshake between the core store path and the
//               UART transmitter (write strobe, byte, ready status).
// Revision    : 1.0 - initial release
// ============================================================================
interface ama_riscv_uart_tx_if;
  logic       store_to_uart;
  logic [7:0] mmio_uart_data_in;
  logic       data_in_ready;

  // Core side: issues writes and polls ready
  modport master (
    output store_to_uart,
    output mmio_uart_data_in,
    input  data_in_ready
  );

  // Transmitter side: accepts writes and reports ready
  modport slave (
    input  store_to_uart,
    input  mmio_uart_data_in,
    output data_in_ready
  );
endinterface
`default_nettype wire

// File: rtl/ama_riscv_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : ama_riscv_uart_tx
// Description : 8N1 UART transmitter with MMIO write port. Optional TX FIFO
//               compiled in when AMA_RISCV_UART_TX_FIFO_EN is defined;
//               otherwise the shift register is the only byte storage.
// Revision    : 1.0 - initial release
// ============================================================================
module ama_riscv_uart_tx #(
  parameter int CLKS_PER_BIT = 1085,
  parameter int FIFO_DEPTH   = 4
) (
  input  wire                 clk,
  input  wire                 rst,
  ama_riscv_uart_tx_if.slave  mmio,
  output logic                serial_out,
  output logic                tx_busy,
  output logic                tx_overflow
);

  localparam int                 c_cnt_w   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [2:0]         c_idx_last = 3'd7;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_start = 2'd1;
  localparam logic [1:0] c_st_data  = 2'd2;
  localparam logic [1:0] c_st_stop  = 2'd3;

  // Reject illegal configurations at elaboration time
  if ((CLKS_PER_BIT < 2) || (CLKS_PER_BIT > 65535) || (FIFO_DEPTH < 2) ||
      (FIFO_DEPTH > 16) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_param
    $error("ama_riscv_uart_tx: illegal CLKS_PER_BIT or FIFO_DEPTH");
  end

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_rst_done;   // low until the first edge after reset release
  logic               w_bit_end;
  logic               w_accept;
  logic               w_load;       // shifter (re)loaded with a new byte this edge
  logic [7:0]         w_load_data;
  logic               w_fifo_empty;
  logic               w_serial_nxt;

  assign w_bit_end = (r_cnt == c_cnt_max);
  assign w_accept  = mmio.store_to_uart & mmio.data_in_ready;

`ifdef AMA_RISCV_UART_TX_FIFO_EN
  localparam int              c_aw      = $clog2(FIFO_DEPTH);
  localparam logic [c_aw:0]   c_full    = (c_aw + 1)'(FIFO_DEPTH);
  localparam logic [c_aw:0]   c_cnt1    = (c_aw + 1)'(1);
  localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_count;
  logic            w_fifo_full;
  logic            w_slot_free;   // shifter free now or at the end of this stop bit
  logic            w_pop;
  logic            w_bypass;
  logic            w_push;

  assign w_fifo_full  = (r_count == c_full);
  assign w_fifo_empty = (r_count == '0);
  assign w_slot_free  = (r_state == c_st_idle) || ((r_state == c_st_stop) && w_bit_end);
  // A write that finds the FIFO empty and the shifter free skips the queue,
  // keeping the same one-cycle start latency as the unbuffered build.
  assign w_pop        = w_slot_free & ~w_fifo_empty;
  assign w_bypass     = w_accept & w_fifo_empty & w_slot_free;
  assign w_push       = w_accept & ~w_bypass;
  assign w_load       = w_pop | w_bypass;
  assign w_load_data  = w_pop ? r_mem[r_rd_ptr] : mmio.mmio_uart_data_in;

  assign mmio.data_in_ready = r_rst_done & ~w_fifo_full;

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      if (w_push && !w_pop)      r_count <= r_count + c_cnt1;
      else if (!w_push && w_pop) r_count <= r_count - c_cnt1;
    end
  end

  // FIFO storage, contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= mmio.mmio_uart_data_in;
  end
`else
  assign w_fifo_empty       = 1'b1;
  assign w_load             = w_accept;
  assign w_load_data        = mmio.mmio_uart_data_in;
  assign mmio.data_in_ready = r_rst_done & (r_state == c_st_idle);
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_st_idle;
    else      r_state <= w_state_nxt;
  end

  // FSM next-state: advance on bit boundaries, chain frames when a byte waits
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (w_load) w_state_nxt = c_st_start;
      c_st_start: if (w_bit_end) w_state_nxt = c_st_data;
      c_st_data:  if (w_bit_end && (r_bit_idx == c_idx_last)) w_state_nxt = c_st_stop;
      c_st_stop:  if (w_bit_end) w_state_nxt = w_load ? c_st_start : c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  // FSM output: line level for the next cycle
  always_comb begin
    w_serial_nxt = 1'b1;
    case (r_state)
      c_st_start: w_serial_nxt = 1'b0;
      c_st_data:  w_serial_nxt = r_shift[0];
      default:    w_serial_nxt = 1'b1;
    endcase
  end

  // Baud counter, bit index, shifter, registered line and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_rst_done  <= 1'b0;
      serial_out  <= 1'b1;
      tx_overflow <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      serial_out <= w_serial_nxt;
      if (mmio.store_to_uart && !mmio.data_in_ready) tx_overflow <= 1'b1;
      if (r_state == c_st_idle) begin
        r_cnt     <= '0;
        r_bit_idx <= '0;
      end else if (w_bit_end) begin
        r_cnt <= '0;
        if (r_state == c_st_data) r_bit_idx <= r_bit_idx + 3'd1;
      end else begin
        r_cnt <= r_cnt + c_cnt_one;
      end
      if (w_load) r_shift <= w_load_data;
      else if ((r_state == c_st_data) && w_bit_end) r_shift <= {1'b0, r_shift[7:1]};
    end
  end

  assign tx_busy = (r_state != c_st_idle) || !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_ama_riscv_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ama_riscv_uart_tx
// Description : Self-checking bench for ama_riscv_uart_tx (CLKS_PER_BIT=4,
//               FIFO_DEPTH=4). Write schedules from a vector table and from
//               random generation are checked cycle by cycle against a
//               frame-timing reference model; the line is also decoded.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ama_riscv_uart_tx;
  localparam int c_clks  = 4;
  localparam int c_depth = 4;
  localparam int c_frame = 10 * c_clks;
  localparam int c_win   = 512;
`ifdef AMA_RISCV_UART_TX_FIFO_EN
  localparam bit c_fifo = 1'b1;
`else
  localparam bit c_fifo = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]      n_wr;
    logic [7:0][7:0] t;     // edge index of each write, relative to scenario start
    logic [7:0][7:0] d;
    logic [3:0]      exp_acc;
    logic            exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic serial_out, tx_busy, tx_overflow;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl[4];

  ama_riscv_uart_tx_if mmio ();

  ama_riscv_uart_tx #(.CLKS_PER_BIT(c_clks), .FIFO_DEPTH(c_depth)) dut (
    .clk        (clk),
    .rst        (rst),
    .mmio       (mmio),
    .serial_out (serial_out),
    .tx_busy    (tx_busy),
    .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_wave(input string nm, input int nbad, input int first,
                          input int got, input int exp);
    n_tests++;
    if (nbad != 0) begin
      n_fail++;
      $display("FAIL %s: %0d bad cycles, first at cycle %0d got %0d expected %0d",
               nm, nbad, first, got, exp);
    end
  endtask

  function automatic vec_t push_wr(input vec_t v, input int t, input logic [7:0] d);
    v.t[v.n_wr] = t[7:0];
    v.d[v.n_wr] = d;
    v.n_wr      = v.n_wr + 4'd1;
    return v;
  endfunction

  // Line level k samples into a frame: start, 8 data LSB first, stop
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    int bi;
    bi = k / c_clks;
    if (bi == 0) return 1'b0;
    if (bi == 9) return 1'b1;
    return b[bi-1];
  endfunction

  function automatic string sig_name(input int s);
    case (s)
      0:       return "serial_out";
      1:       return "tx_busy";
      2:       return "data_in_ready";
      default: return "tx_overflow";
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    mmio.store_to_uart = 1'b0;
    mmio.mmio_uart_data_in = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_scen(input vec_t v, input int id, input bit from_tbl, input bit do_rst);
    int acc[8], st[8];
    logic [7:0] by[8];
    logic a_ser[c_win];
    logic [7:0] dec[16];
    int na, last_end, drop_first, t_end, q, nw, n_dec, nbad_d, i;
    int nbad[4], first[4], fgot[4], fexp[4];
    logic got[4], exp[4];
    logic act_frame;
    if (do_rst) do_reset();
    nw = int'(v.n_wr);
    na = 0; last_end = -1000; drop_first = c_win;
    // Reference model: frames occupy c_frame edges each, start as soon as
    // both the byte and the line are available, and bytes beyond the
    // storage available at the write edge are dropped.
    for (int w = 0; w < nw; w++) begin
      int t;
      bit ok;
      t = int'(v.t[w]);
      if (c_fifo) begin
        q = 0;
        for (int j = 0; j < na; j++) if (acc[j] < t && t <= st[j]) q++;
        ok = (q < c_depth);
      end else begin
        ok = (t > last_end);
      end
      if (ok) begin
        acc[na] = t; by[na] = v.d[w];
        st[na] = (t > last_end) ? t : last_end;
        last_end = st[na] + c_frame;
        na++;
      end else if (drop_first == c_win) begin
        drop_first = t;
      end
    end
    t_end = (last_end > int'(v.t[nw-1])) ? last_end + 4 : int'(v.t[nw-1]) + 4;
    if (t_end > c_win) t_end = c_win;
    for (int s = 0; s < 4; s++) begin nbad[s] = 0; first[s] = 0; fgot[s] = 0; fexp[s] = 0; end
    for (int cyc = 0; cyc < t_end; cyc++) begin
      mmio.store_to_uart = 1'b0;
      for (int w = 0; w < nw; w++) if (int'(v.t[w]) == cyc) begin
        mmio.store_to_uart = 1'b1;
        mmio.mmio_uart_data_in = v.d[w];
      end
      @(negedge clk);
      exp[0] = 1'b1; exp[1] = 1'b0; q = 0; act_frame = 1'b0;
      for (int j = 0; j < na; j++) begin
        if (st[j] <= cyc - 1 && cyc - 1 < st[j] + c_frame) exp[0] = frame_bit(by[j], cyc - 1 - st[j]);
        if (acc[j] <= cyc && cyc < st[j] + c_frame) exp[1] = 1'b1;
        if (acc[j] <= cyc && cyc < st[j]) q++;
        if (st[j] <= cyc && cyc < st[j] + c_frame) act_frame = 1'b1;
      end
      exp[2] = c_fifo ? (q < c_depth) : !act_frame;
      exp[3] = (cyc >= drop_first);
      got[0] = serial_out; got[1] = tx_busy; got[2] = mmio.data_in_ready; got[3] = tx_overflow;
      a_ser[cyc] = serial_out;
      for (int s = 0; s < 4; s++) if (got[s] !== exp[s]) begin
        if (nbad[s] == 0) begin first[s] = cyc; fgot[s] = int'(got[s]); fexp[s] = int'(exp[s]); end
        nbad[s]++;
      end
    end
    mmio.store_to_uart = 1'b0;
    for (int s = 0; s < 4; s++)
      chk_wave($sformatf("scen%0d %s", id, sig_name(s)), nbad[s], first[s], fgot[s], fexp[s]);
    // Decode the captured line like a receiver sampling mid-bit
    n_dec = 0; i = 0;
    while (i < t_end) begin
      if (a_ser[i] == 1'b0 && (i + 9 * c_clks + c_clks / 2) < t_end) begin
        if (a_ser[i + 9 * c_clks + c_clks / 2] == 1'b1 && n_dec < 16) begin
          for (int k = 0; k < 8; k++) dec[n_dec][k] = a_ser[i + (k + 1) * c_clks + c_clks / 2];
          n_dec++;
        end
        i = i + 9 * c_clks + c_clks / 2;
      end else begin
        i++;
      end
    end
    nbad_d = 0;
    for (int k = 0; k < n_dec && k < na; k++) if (dec[k] != by[k]) nbad_d++;
    chk($sformatf("scen%0d decoded frames", id), n_dec, from_tbl ? int'(v.exp_acc) : na);
    chk($sformatf("scen%0d decoded byte errors", id), nbad_d, 0);
    chk($sformatf("scen%0d final tx_overflow", id), int'(tx_overflow),
        from_tbl ? int'(v.exp_ovf) : int'(drop_first != c_win));
  endtask

  initial begin
    vec_t v;
    int   nbad, t;
    rst = 1'b0;
    mmio.store_to_uart = 1'b0;
    mmio.mmio_uart_data_in = 8'h00;

    // Vector table: write schedules and hand-computed frame/overflow results
    for (int k = 0; k < 4; k++) tbl[k] = '0;
    tbl[0] = push_wr(tbl[0], 0, 8'hA5); tbl[0].exp_acc = 4'd1; tbl[0].exp_ovf = 1'b0;
`ifdef AMA_RISCV_UART_TX_FIFO_EN
    tbl[1] = push_wr(tbl[1], 0, 8'h00); tbl[1] = push_wr(tbl[1], 1, 8'hFF);
    tbl[1].exp_acc = 4'd2; tbl[1].exp_ovf = 1'b0;
    for (int k = 0; k < 6; k++) tbl[2] = push_wr(tbl[2], k, 8'h11 * (k + 1));
    tbl[2].exp_acc = 4'd5; tbl[2].exp_ovf = 1'b1;
    tbl[3] = push_wr(tbl[3], 0, 8'h5A); tbl[3] = push_wr(tbl[3], 40, 8'hC3);
    tbl[3].exp_acc = 4'd2; tbl[3].exp_ovf = 1'b0;
`else
    tbl[1] = push_wr(tbl[1], 0, 8'h3C); tbl[1] = push_wr(tbl[1], 10, 8'h55);
    tbl[1].exp_acc = 4'd1; tbl[1].exp_ovf = 1'b1;
    tbl[2] = push_wr(tbl[2], 0, 8'h5A); tbl[2] = push_wr(tbl[2], 40, 8'hC3);
    tbl[2].exp_acc = 4'd1; tbl[2].exp_ovf = 1'b1;
    tbl[3] = push_wr(tbl[3], 0, 8'h5A); tbl[3] = push_wr(tbl[3], 41, 8'hC3);
    tbl[3].exp_acc = 4'd2; tbl[3].exp_ovf = 1'b0;
`endif

    // Reset values while held, then ready on the first edge after release
    repeat (2) @(negedge clk);
    chk("reset serial_out", int'(serial_out), 1);
    chk("reset data_in_ready", int'(mmio.data_in_ready), 0);
    chk("reset tx_busy", int'(tx_busy), 0);
    chk("reset tx_overflow", int'(tx_overflow), 0);
    rst = 1'b1;
    #1;
    chk("ready before first edge", int'(mmio.data_in_ready), 0);
    @(negedge clk);
    chk("ready after first edge", int'(mmio.data_in_ready), 1);

    // Long idle after reset keeps the line quiet
    nbad = 0;
    repeat (100) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || mmio.data_in_ready !== 1'b1 || tx_busy !== 1'b0) nbad++;
    end
    chk("idle 100 cycles bad samples", nbad, 0);

    for (int k = 0; k < 4; k++) run_scen(tbl[k], k, 1'b1, 1'b1);

    for (int r = 0; r < 12; r++) begin
      v = '0;
      t = $urandom_range(0, 3);
      for (int k = 0; k < int'($urandom_range(1, 7)); k++) begin
        v = push_wr(v, t, 8'($urandom));
        t = t + $urandom_range(1, 30);
      end
      run_scen(v, 100 + r, 1'b0, 1'b1);
    end

    // Reset in the middle of a 0xA5 frame, then a clean 0x81 frame
    do_reset();
    mmio.store_to_uart = 1'b1;
    mmio.mmio_uart_data_in = 8'hA5;
    @(negedge clk);
    mmio.store_to_uart = 1'b0;
    repeat (11) @(negedge clk);
    chk("mid-frame serial_out before reset", int'(serial_out), 0);
    chk("mid-frame tx_busy before reset", int'(tx_busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("async reset serial_out", int'(serial_out), 1);
    chk("async reset tx_busy", int'(tx_busy), 0);
    chk("async reset data_in_ready", int'(mmio.data_in_ready), 0);
    chk("async reset tx_overflow", int'(tx_overflow), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    nbad = 0;
    repeat (3) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || tx_busy !== 1'b0) nbad++;
    end
    chk("no frame resumes after reset", nbad, 0);
    v = '0;
    v = push_wr(v, 0, 8'h81);
    v.exp_acc = 4'd1;
    v.exp_ovf = 1'b0;
    run_scen(v, 200, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
